tcp_tx_pipe_ctrl: RTL and testbench
===================================

# tcp_tx_pipe_ctrl

Control FSM that sequences the TCP transmit-path datapath (`tcp_tx_datap`) for one scheduler grant at a time. It accepts a scheduler TX request, reads per-flow state (tail pointer, TX state, RX state, four-tuple), then strobes the datapath's store/calc enables. It emits the packet header/payload descriptor, the next-TX-state write and the scheduler update command, each with independent val/rdy handshakes. It sits between the TX scheduler, the per-flow state memories, and the TX packet assembly stage.

## Interface
Parameters:
- none; widths come from `tcp_pkg`/`tcp_misc_pkg`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `sched_tx_req_val` in 1 / `sched_tx_req_rdy` out 1  scheduler grant handshake
- `tx_tail_ptr_rd_req_val` out 1 / `_rdy` in 1; `tx_tail_ptr_rd_resp_val` in 1 / `_rdy` out 1  tail-pointer memory
- `curr_tx_state_rd_req_val`/`_rdy`, `curr_tx_state_rd_resp_val`/`_rdy`  TX-state memory, same directions
- `rx_state_rd_req_val`/`_rdy`, `rx_state_rd_resp_val`/`_rdy`  RX-state memory, same directions
- `tuple_rd_req_val`/`_rdy`, `tuple_rd_resp_val`/`_rdy`  four-tuple memory, same directions
- `next_tx_state_wr_req_val` out 1 / `_rdy` in 1  TX-state write
- `tx_sched_update_val` out 1 / `_rdy` in 1  scheduler update command
- `proto_calc_tx_pkt_val` out 1 / `_rdy` in 1  packet to assembly stage
- `datap_ctrl_produce_pkt` in 1  datapath "packet non-empty" indication
- `ctrl_datap_store_flowid`, `ctrl_datap_store_state`, `ctrl_datap_store_tuple`, `ctrl_datap_store_calc`  out 1 each  datapath load strobes
- `perf_pkt_cnt` out 32  packets sent
- `perf_empty_cnt` out 32  grants that produced no packet

## Operation
States: READY, RD_REQ, RD_RESP, CALC, DECIDE, OUTPUT.
- READY: `sched_tx_req_rdy`=1. On val: `store_flowid`=1 and go to RD_REQ.
- RD_REQ: assert the four `*_rd_req_val` outputs. Each request drops after its own handshake; a sticky done bit tracks each one. Go to RD_RESP the cycle all four are done, counting a handshake in the current cycle.
- RD_RESP: state group = tail, TX and RX responses, joined.
  - Assert all three resp_rdy and `store_state`=1 only in a cycle where all three resp_val are high.
  - Tuple is independent: when `tuple_rd_resp_val` is high and not yet captured, `tuple_rd_resp_rdy`=1 and `store_tuple`=1.
  - Either group may complete first. Go to CALC when both have been captured.
- CALC: `store_calc`=1 for exactly one cycle, then DECIDE.
- DECIDE: sample `datap_ctrl_produce_pkt`, which is valid because `payload_desc_reg` is now loaded.
  - If 1: set mask {pkt, wr, upd}.
  - If 0: set mask {upd} only; the TX state is not written.
  - Go to OUTPUT.
- OUTPUT: assert val on each masked output until handshaken, tracked with sticky done bits. Go to READY when all masked outputs are done.
- Store strobes are single-cycle and never asserted outside the states listed above.
- Every val, once asserted, is held until its rdy.

## Timing
- Reset (async assert, sync release is external): state=READY, all done bits and mask cleared, counters=0. Output reset values: `sched_tx_req_rdy`=1, every other output 0.
- Reset asserted mid-operation aborts immediately. In-flight vals drop and no partial write is retried.
- Minimum grant-to-grant interval: 6 cycles, with all rdys high and responses valid on first RD_RESP cycle: READY, RD_REQ, RD_RESP, CALC, DECIDE, OUTPUT.
- Response vals seen in RD_REQ are ignored and must be held by the memories.
- Counters saturate at 32'hFFFF_FFFF.
  - `perf_pkt_cnt` increments on the `proto_calc_tx_pkt` handshake.
  - `perf_empty_cnt` increments on DECIDE with produce=0.

## Configuration
- `TCP_TX_CTRL_PERF_EN` defined: both perf counters are implemented as specified.
- Not defined: counter logic is not built, and `perf_pkt_cnt`/`perf_empty_cnt` are constant 0. Ports remain present.

## Test plan
- Single grant, all rdys=1, memory responses one cycle after request, produce=1 → store strobes in order flowid(c0), state(c2), tuple(c2), calc(c3); pkt/wr/upd val on c5; `sched_tx_req_rdy` high again c6; `perf_pkt_cnt`=1.
- Produce=0 → only `tx_sched_update_val` asserted in OUTPUT; `next_tx_state_wr_req_val` and `proto_calc_tx_pkt_val` stay 0; `perf_empty_cnt`=1.
- Tuple response 3 cycles before state group, and TX-state resp delayed 4 cycles after tail/RX → `store_tuple` once early; `store_state` exactly once, only when all three vals are high; CALC follows.
- In OUTPUT, `proto_calc_tx_pkt_rdy` held low 5 cycles while the others accept immediately → wr/upd val drop after 1 cycle; pkt val held 5 cycles; single return to READY.
- `rst_n` pulsed low during RD_RESP → all vals 0 asynchronously, `sched_tx_req_rdy`=1; the next grant completes normally.
- Macro undefined, 3 grants → perf outputs remain 0.

Source files
------------

// File: rtl/tcp_tx_pipe_ctrl.sv
// ============================================================================
// tcp_tx_pipe_ctrl : sequences tcp_tx_datap for one scheduler grant at a time.
// Optional: define TCP_TX_CTRL_PERF_EN to build the perf counters. Rev 1.0
// ============================================================================
`default_nettype none

module tcp_tx_pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        sched_tx_req_val,
  output logic        sched_tx_req_rdy,

  output logic        tx_tail_ptr_rd_req_val,
  input  logic        tx_tail_ptr_rd_req_rdy,
  input  logic        tx_tail_ptr_rd_resp_val,
  output logic        tx_tail_ptr_rd_resp_rdy,

  output logic        curr_tx_state_rd_req_val,
  input  logic        curr_tx_state_rd_req_rdy,
  input  logic        curr_tx_state_rd_resp_val,
  output logic        curr_tx_state_rd_resp_rdy,

  output logic        rx_state_rd_req_val,
  input  logic        rx_state_rd_req_rdy,
  input  logic        rx_state_rd_resp_val,
  output logic        rx_state_rd_resp_rdy,

  output logic        tuple_rd_req_val,
  input  logic        tuple_rd_req_rdy,
  input  logic        tuple_rd_resp_val,
  output logic        tuple_rd_resp_rdy,

  output logic        next_tx_state_wr_req_val,
  input  logic        next_tx_state_wr_req_rdy,

  output logic        tx_sched_update_val,
  input  logic        tx_sched_update_rdy,

  output logic        proto_calc_tx_pkt_val,
  input  logic        proto_calc_tx_pkt_rdy,

  input  logic        datap_ctrl_produce_pkt,

  output logic        ctrl_datap_store_flowid,
  output logic        ctrl_datap_store_state,
  output logic        ctrl_datap_store_tuple,
  output logic        ctrl_datap_store_calc,

  output logic [31:0] perf_pkt_cnt,
  output logic [31:0] perf_empty_cnt
);

  typedef enum logic [2:0] {
    ST_READY   = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_CALC    = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_OUTPUT  = 3'd5
  } state_t;

  state_t     r_state;
  logic       r_sched_rdy;
  // Outstanding request/output vals double as the inverted sticky done bits.
  logic [3:0] r_req_val;    // {tuple, rx, tx, tail}
  logic [2:0] r_out_val;    // {pkt, wr, upd}
  logic       r_state_cap;
  logic       r_tuple_cap;

  logic [3:0] w_req_rdy;
  logic [3:0] w_req_pend;
  logic [2:0] w_out_rdy;
  logic [2:0] w_out_pend;
  logic [2:0] w_out_hs;
  logic       w_grant;
  logic       w_state_go;
  logic       w_tuple_go;
  logic       w_resp_done;

  assign w_req_rdy  = {tuple_rd_req_rdy, rx_state_rd_req_rdy,
                       curr_tx_state_rd_req_rdy, tx_tail_ptr_rd_req_rdy};
  assign w_req_pend = r_req_val & ~w_req_rdy;
  assign w_out_rdy  = {proto_calc_tx_pkt_rdy, next_tx_state_wr_req_rdy, tx_sched_update_rdy};
  assign w_out_pend = r_out_val & ~w_out_rdy;
  assign w_out_hs   = r_out_val & w_out_rdy;

  assign w_grant    = r_sched_rdy & sched_tx_req_val;
  // The three state responses are consumed together so the datapath loads a coherent snapshot.
  assign w_state_go = (r_state == ST_RD_RESP) & ~r_state_cap & tx_tail_ptr_rd_resp_val &
                      curr_tx_state_rd_resp_val & rx_state_rd_resp_val;
  assign w_tuple_go = (r_state == ST_RD_RESP) & ~r_tuple_cap & tuple_rd_resp_val;
  assign w_resp_done = (r_state_cap | w_state_go) & (r_tuple_cap | w_tuple_go);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_READY;
      r_sched_rdy <= 1'b1;
      r_req_val   <= 4'd0;
      r_out_val   <= 3'd0;
      r_state_cap <= 1'b0;
      r_tuple_cap <= 1'b0;
    end else begin
      case (r_state)
        ST_READY: begin
          if (w_grant) begin
            r_sched_rdy <= 1'b0;
            r_req_val   <= 4'hF;
            r_state     <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          r_req_val <= w_req_pend;
          if (w_req_pend == 4'd0) r_state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (w_state_go) r_state_cap <= 1'b1;
          if (w_tuple_go) r_tuple_cap <= 1'b1;
          if (w_resp_done) begin
            r_state_cap <= 1'b0;
            r_tuple_cap <= 1'b0;
            r_state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          // An empty grant still updates the scheduler but leaves the TX state untouched.
          r_out_val <= datap_ctrl_produce_pkt ? 3'b111 : 3'b001;
          r_state   <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          r_out_val <= w_out_pend;
          if (w_out_pend == 3'd0) begin
            r_sched_rdy <= 1'b1;
            r_state     <= ST_READY;
          end
        end
        default: begin
          r_state     <= ST_READY;
          r_sched_rdy <= 1'b1;
          r_req_val   <= 4'd0;
          r_out_val   <= 3'd0;
          r_state_cap <= 1'b0;
          r_tuple_cap <= 1'b0;
        end
      endcase
    end
  end

  assign sched_tx_req_rdy          = r_sched_rdy;

  assign tx_tail_ptr_rd_req_val    = r_req_val[0];
  assign curr_tx_state_rd_req_val  = r_req_val[1];
  assign rx_state_rd_req_val       = r_req_val[2];
  assign tuple_rd_req_val          = r_req_val[3];

  assign tx_tail_ptr_rd_resp_rdy   = w_state_go;
  assign curr_tx_state_rd_resp_rdy = w_state_go;
  assign rx_state_rd_resp_rdy      = w_state_go;
  assign tuple_rd_resp_rdy         = w_tuple_go;

  assign tx_sched_update_val       = r_out_val[0];
  assign next_tx_state_wr_req_val  = r_out_val[1];
  assign proto_calc_tx_pkt_val     = r_out_val[2];

  assign ctrl_datap_store_flowid   = w_grant;
  assign ctrl_datap_store_state    = w_state_go;
  assign ctrl_datap_store_tuple    = w_tuple_go;
  assign ctrl_datap_store_calc     = (r_state == ST_CALC);

`ifdef TCP_TX_CTRL_PERF_EN
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_empty_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt   <= 32'd0;
      r_empty_cnt <= 32'd0;
    end else begin
      if (w_out_hs[2] && (r_pkt_cnt != 32'hFFFF_FFFF))
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if ((r_state == ST_DECIDE) && !datap_ctrl_produce_pkt && (r_empty_cnt != 32'hFFFF_FFFF))
        r_empty_cnt <= r_empty_cnt + 32'd1;
    end
  end

  assign perf_pkt_cnt   = r_pkt_cnt;
  assign perf_empty_cnt = r_empty_cnt;
`else
  logic [2:0] w_unused_hs;
  assign w_unused_hs    = w_out_hs;
  assign perf_pkt_cnt   = 32'd0;
  assign perf_empty_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcp_tx_pipe_ctrl.sv
// tb_tcp_tx_pipe_ctrl : randomized grants against a transaction-level model of
// the TX control sequence (per-grant event counts, handshake rules, latencies).
`default_nettype none

module tb_tcp_tx_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sched_val;
  wire        sched_rdy;
  logic [3:0] req_rdy;
  wire  [3:0] req_val;
  logic [3:0] resp_val;
  wire  [3:0] resp_rdy;
  logic [2:0] out_rdy;
  wire  [2:0] out_val;
  logic       produce;
  wire        st_flow, st_state, st_tuple, st_calc;
  wire [31:0] perf_pkt, perf_empty;

  tcp_tx_pipe_ctrl dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .sched_tx_req_val          (sched_val),
    .sched_tx_req_rdy          (sched_rdy),
    .tx_tail_ptr_rd_req_val    (req_val[0]),
    .tx_tail_ptr_rd_req_rdy    (req_rdy[0]),
    .tx_tail_ptr_rd_resp_val   (resp_val[0]),
    .tx_tail_ptr_rd_resp_rdy   (resp_rdy[0]),
    .curr_tx_state_rd_req_val  (req_val[1]),
    .curr_tx_state_rd_req_rdy  (req_rdy[1]),
    .curr_tx_state_rd_resp_val (resp_val[1]),
    .curr_tx_state_rd_resp_rdy (resp_rdy[1]),
    .rx_state_rd_req_val       (req_val[2]),
    .rx_state_rd_req_rdy       (req_rdy[2]),
    .rx_state_rd_resp_val      (resp_val[2]),
    .rx_state_rd_resp_rdy      (resp_rdy[2]),
    .tuple_rd_req_val          (req_val[3]),
    .tuple_rd_req_rdy          (req_rdy[3]),
    .tuple_rd_resp_val         (resp_val[3]),
    .tuple_rd_resp_rdy         (resp_rdy[3]),
    .next_tx_state_wr_req_val  (out_val[1]),
    .next_tx_state_wr_req_rdy  (out_rdy[1]),
    .tx_sched_update_val       (out_val[0]),
    .tx_sched_update_rdy       (out_rdy[0]),
    .proto_calc_tx_pkt_val     (out_val[2]),
    .proto_calc_tx_pkt_rdy     (out_rdy[2]),
    .datap_ctrl_produce_pkt    (produce),
    .ctrl_datap_store_flowid   (st_flow),
    .ctrl_datap_store_state    (st_state),
    .ctrl_datap_store_tuple    (st_tuple),
    .ctrl_datap_store_calc     (st_calc),
    .perf_pkt_cnt              (perf_pkt),
    .perf_empty_cnt            (perf_empty)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stimulus knobs
  bit full;
  int stall_left;
  int dl[4];                 // response latency per memory, 0 = random 1..4

  // Memory responder model
  bit pend[4];
  int cnt[4];

  // Per-grant observations
  int h_req[4];
  int n_flow, n_state, n_tuple, n_calc;
  int h_pkt, h_wr, h_upd, c_pkt, c_wr, c_upd;
  int t, t_state, t_tuple, t_calc, t_out;
  logic [6:0] pv, pr;

  // Reference perf totals
  int m_pkt, m_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_grant();
    for (int i = 0; i < 4; i++) h_req[i] = 0;
    n_flow = 0; n_state = 0; n_tuple = 0; n_calc = 0;
    h_pkt = 0; h_wr = 0; h_upd = 0; c_pkt = 0; c_wr = 0; c_upd = 0;
    t = 0; t_state = -1; t_tuple = -1; t_calc = -1; t_out = -1;
  endtask

  // One clock: drive at negedge, sample 1 time unit later, advance to next negedge.
  task automatic cycle();
    logic [6:0] v, r;
    bit req_done;
    for (int i = 0; i < 4; i++) begin
      req_rdy[i]  = full ? 1'b1 : ($urandom_range(0, 2) != 0);
      resp_val[i] = pend[i] && (cnt[i] == 0);
    end
    out_rdy[0] = full ? 1'b1 : ($urandom_range(0, 2) != 0);
    out_rdy[1] = full ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (out_val[2] && stall_left > 0) begin
      out_rdy[2] = 1'b0;
      stall_left--;
    end else begin
      out_rdy[2] = full ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
    #1;
    req_done = (h_req[0] == 1) && (h_req[1] == 1) && (h_req[2] == 1) && (h_req[3] == 1);
    v = {out_val, req_val};
    r = {out_rdy, req_rdy};
    for (int i = 0; i < 7; i++)
      if (pv[i] && !pr[i]) chk($sformatf("val_hold[%0d]", i), v[i], 1'b1);
    chk("flowid_strobe", st_flow, sched_rdy & sched_val);
    chk("state_resp_rdy", resp_rdy[2:0], {3{st_state}});
    chk("state_join", st_state & ~(&resp_val[2:0]), 1'b0);
    chk("tuple_resp_rdy", resp_rdy[3], st_tuple);
    chk("tuple_val", st_tuple & ~resp_val[3], 1'b0);
    if (req_done && (&resp_val[2:0]) && n_state == 0) chk("state_take", st_state, 1'b1);
    if (req_done && resp_val[3] && n_tuple == 0) chk("tuple_take", st_tuple, 1'b1);
    if (st_calc) chk("calc_order", {n_state == 1, n_tuple == 1, n_calc == 0}, 3'b111);
    if (|out_val) chk("out_order", n_calc, 1);
    chk("empty_no_pkt_wr", out_val[2:1] & {2{~produce}}, 2'b00);

    n_flow  += st_flow;
    n_state += st_state;
    n_tuple += st_tuple;
    n_calc  += st_calc;
    if (st_state && t_state < 0) t_state = t;
    if (st_tuple && t_tuple < 0) t_tuple = t;
    if (st_calc && t_calc < 0) t_calc = t;
    if ((|out_val) && t_out < 0) t_out = t;
    c_upd += out_val[0]; c_wr += out_val[1]; c_pkt += out_val[2];
    h_upd += out_val[0] & out_rdy[0];
    h_wr  += out_val[1] & out_rdy[1];
    h_pkt += out_val[2] & out_rdy[2];
    m_pkt += out_val[2] & out_rdy[2];
    for (int i = 0; i < 4; i++) begin
      h_req[i] += req_val[i] & req_rdy[i];
      if (resp_val[i] && resp_rdy[i]) pend[i] = 1'b0;
      else if (pend[i] && cnt[i] > 0) cnt[i]--;
      if (req_val[i] && req_rdy[i]) begin
        pend[i] = 1'b1;
        cnt[i]  = ((dl[i] == 0) ? int'($urandom_range(1, 4)) : dl[i]) - 1;
      end
    end
    pv = v;
    pr = r;
    t++;
    @(negedge clk);
  endtask

  task automatic check_perf(input string tag);
`ifdef TCP_TX_CTRL_PERF_EN
    chk({tag, "_perf_pkt"}, perf_pkt, m_pkt);
    chk({tag, "_perf_empty"}, perf_empty, m_empty);
`else
    chk({tag, "_perf_pkt"}, perf_pkt, 0);
    chk({tag, "_perf_empty"}, perf_empty, 0);
`endif
  endtask

  // One complete grant; timed = all-ready/latency-1 expectations, stall = pkt rdy low cycles.
  task automatic do_grant(input logic prod, input bit fullr, input int d0, input int d1,
                          input int d2, input int d3, input bit timed, input int stall);
    full = fullr;
    dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
    stall_left = stall;
    chk("idle_ready", sched_rdy, 1'b1);
    clear_grant();
    produce   = prod;
    sched_val = 1'b1;
    cycle();
    sched_val = 1'b0;
    while (!sched_rdy && t < 300) cycle();
    chk("grant_timeout", sched_rdy, 1'b1);
    if (!prod) m_empty++;
    for (int i = 0; i < 4; i++) chk($sformatf("req_handshakes[%0d]", i), h_req[i], 1);
    chk("n_flowid", n_flow, 1);
    chk("n_store_state", n_state, 1);
    chk("n_store_tuple", n_tuple, 1);
    chk("n_store_calc", n_calc, 1);
    chk("pkt_handshakes", h_pkt, prod ? 1 : 0);
    chk("wr_handshakes", h_wr, prod ? 1 : 0);
    chk("upd_handshakes", h_upd, 1);
    check_perf("grant");
    if (timed) begin
      chk("t_state", t_state, 2);
      chk("t_tuple", t_tuple, 2);
      chk("t_calc", t_calc, 3);
      chk("t_out", t_out, 5);
      chk("t_ready_again", t, 6);
    end
    if (stall > 0) begin
      chk("stall_pkt_cycles", c_pkt, stall + 1);
      chk("stall_wr_cycles", c_wr, 1);
      chk("stall_upd_cycles", c_upd, 1);
    end
  endtask

  initial begin
    sched_val = 1'b0; produce = 1'b0;
    req_rdy = 4'd0; resp_val = 4'd0; out_rdy = 3'd0;
    full = 1'b1; stall_left = 0;
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; cnt[i] = 0; dl[i] = 1; end
    pv = 7'd0; pr = 7'd0; m_pkt = 0; m_empty = 0;
    clear_grant();

    // Reset values
    @(negedge clk);
    chk("rst_sched_rdy", sched_rdy, 1'b1);
    chk("rst_req_val", req_val, 4'd0);
    chk("rst_out_val", out_val, 3'd0);
    chk("rst_strobes", {st_flow, st_state, st_tuple, st_calc}, 4'd0);
    check_perf("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum-latency grants, packet and empty
    do_grant(1'b1, 1'b1, 1, 1, 1, 1, 1'b1, 0);
    do_grant(1'b0, 1'b1, 1, 1, 1, 1, 1'b1, 0);

    // Tuple early, TX state late after tail/RX
    do_grant(1'b1, 1'b1, 4, 8, 4, 1, 1'b0, 0);

    // Packet output back-pressured while wr/upd accept at once
    do_grant(1'b1, 1'b1, 1, 1, 1, 1, 1'b0, 5);

    // Reset mid RD_RESP
    full = 1'b1;
    for (int i = 0; i < 4; i++) dl[i] = 6;
    clear_grant();
    produce = 1'b1;
    sched_val = 1'b1;
    cycle();
    sched_val = 1'b0;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_val", req_val, 4'd0);
    chk("midrst_out_val", out_val, 3'd0);
    chk("midrst_resp_rdy", resp_rdy, 4'd0);
    chk("midrst_sched_rdy", sched_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; cnt[i] = 0; end
    pv = 7'd0; pr = 7'd0; m_pkt = 0; m_empty = 0;
    check_perf("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_grant(1'b1, 1'b1, 1, 1, 1, 1, 1'b1, 0);

    // Randomized grants: random back-pressure, latencies, produce and idle gaps
    for (int g = 0; g < 40; g++) begin
      do_grant(logic'($urandom_range(0, 1)), 1'b0, 0, 0, 0, 0, 1'b0, 0);
      sched_val = 1'b0;
      repeat ($urandom_range(0, 2)) cycle();
    end
    full = 1'b1;
    check_perf("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
